alu_result_stage: RTL

- Registered output stage directly downstream of the N-bit ALU.
- Captures each ALU result, NZCV flags and opcode into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Maintains sticky flags and a saturating count of accepted operations.
- Drives a registered carry-feedback bit into the ALU carryin, so multi-word add chains can run across consecutive operations.

---
 rtl/alu_result_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the ALU. Each accepted ALU result, its
//   NZCV flags and the opcode that produced it are held in a 2-entry skid
//   buffer. Both sides use valid/ready handshakes. The stage also keeps a
//   sticky OR of all accepted flags and a saturating count of accepted
//   operations. It returns a registered carry bit to the ALU carry-in, so a
//   multi-word add can be split across consecutive operations.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     upstream handshake
//   in_result/flags/op    ALU result, flags {n,z,c,v}, opcode (0 = add)
//   out_valid/out_ready   downstream handshake
//   out_result/flags/op   head entry of the buffer
//   chain_en, carry_fb    carry feedback enable and registered carry out
//   sticky_clr            clear for sticky_flags
//   sticky_flags          OR of flags accepted since the last clear
//   op_count              saturating count of accepted entries
module alu_result_stage #(
    parameter int WIDTH   = 3,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_result,
    input  logic [3:0]         in_flags,
    input  logic [2:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [3:0]         out_flags,
    output logic [2:0]         out_op,
    input  logic               chain_en,
    output logic               carry_fb,
    input  logic               sticky_clr,
    output logic [3:0]         sticky_flags,
    output logic [COUNT_W-1:0] op_count
);

    // Entry layout: {result, flags, op}
    localparam int ENT_W = WIDTH + 7;

    // The head entry is held in _p0 and the second entry in _p1.
    // vld_p1 is set only while vld_p0 is set.
    logic             vld_p0, vld_p1;
    logic [ENT_W-1:0] ent_p0, ent_p1;
    logic [ENT_W-1:0] in_ent;
    logic             accept, pop;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    assign in_ent    = {in_result, in_flags, in_op};
    // Ready depends only on registered occupancy. It never depends on out_ready.
    assign in_ready  = ~vld_p1;
    assign out_valid = vld_p0;
    assign accept    = in_valid & in_ready;
    assign pop       = vld_p0 & out_ready;
    assign {out_result, out_flags, out_op} = ent_p0;

    // ---- buffer stage: occupancy and entry storage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            ent_p0 <= '0;
            ent_p1 <= '0;
        end else begin
            case ({vld_p1, vld_p0})
                2'b00: begin
                    if (accept) begin
                        ent_p0 <= in_ent;
                        vld_p0 <= 1'b1;
                    end
                end
                2'b01: begin
                    if (accept && pop) begin
                        ent_p0 <= in_ent;
                    end else if (pop) begin
                        vld_p0 <= 1'b0;
                    end else if (accept) begin
                        ent_p1 <= in_ent;
                        vld_p1 <= 1'b1;
                    end
                end
                2'b11: begin
                    // No accept is possible while the buffer is full.
                    if (pop) begin
                        ent_p0 <= ent_p1;
                        vld_p1 <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding. Recover by emptying the buffer.
                    vld_p0 <= 1'b0;
                    vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    // ---- side-state stage: carry feedback, sticky flags, op counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_fb     <= 1'b0;
            sticky_flags <= 4'b0;
            op_count     <= '0;
        end else begin
            // Only accepted add operations update the carry. Other opcodes hold it.
            if (!chain_en) begin
                carry_fb <= 1'b0;
            end else if (accept && (in_op == 3'd0)) begin
                carry_fb <= in_flags[1];
            end

            // If a clear and an accept happen in the same cycle, the new flags are kept.
            sticky_flags <= (sticky_clr ? 4'b0 : sticky_flags) | (accept ? in_flags : 4'b0);

            if (accept) begin
                op_count <= sat_inc(op_count);
            end
        end
    end

endmodule
